ulpi_link_ctrl: RTL and testbench

ULPI_LINK_CTRL -- requirements
Module: ulpi_link_ctrl

---
 rtl/ulpi_link_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_ulpi_link_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_link_ctrl
// ULPI link-side controller: PHY register access, TX packets, RX byte FIFO.
// Revision : 1.0
// ============================================================================
module ulpi_link_ctrl #(
  parameter int RX_DEPTH  = 16,
  parameter int TX_DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ulpi_dir,
  input  logic                 ulpi_nxt,
  input  logic [7:0]           ulpi_data_i,
  output logic [7:0]           ulpi_data_o,
  output logic                 ulpi_data_oe,
  output logic                 ulpi_stp,
  input  logic                 reg_req,
  input  logic                 reg_we,
  input  logic [5:0]           reg_addr,
  input  logic [7:0]           reg_wdata,
  output logic                 reg_done,
  output logic                 reg_abort,
  output logic [7:0]           reg_rdata,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 tx_last,
  input  logic [TX_DATA_W-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [TX_DATA_W-1:0] rx_data,
  output logic                 rx_overflow,
  output logic [7:0]           rx_cmd,
  output logic                 busy
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] C_FULL = (AW + 1)'(RX_DEPTH);

  generate
    if (TX_DATA_W != 8) begin : g_bad_width
      $error("ulpi_link_ctrl: TX_DATA_W must be 8");
    end
    if (RX_DEPTH < 4 || RX_DEPTH > 256 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ulpi_link_ctrl: RX_DEPTH must be a power of two in 4..256");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_TX_CMD    = 4'd1,
    S_TX_DATA   = 4'd2,
    S_TX_STP    = 4'd3,
    S_REG_CMD   = 4'd4,
    S_REG_WDATA = 4'd5,
    S_REG_TURN  = 4'd6,
    S_REG_RDATA = 4'd7,
    S_REG_STP   = 4'd8
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_dir;
  logic                  r_stp;
  logic                  r_we;
  logic                  r_tx_drop;
  logic [7:0]            r_reg_rdata;
  logic [7:0]            r_rx_cmd;
  logic                  r_ovf;
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [TX_DATA_W-1:0]  r_mem [RX_DEPTH];

  logic                  w_turn;
  logic                  w_oe;
  logic                  w_rx_ok;
  logic [7:0]            w_data_o;
  logic                  w_tx_ready;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_capture_rd;
  logic                  w_drop_set;
  logic [AW:0]           w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_push;

  assign w_turn  = ulpi_dir != r_dir;
  assign w_oe    = !ulpi_dir && !w_turn;
  assign w_rx_ok = ulpi_dir && !w_turn && (r_state != S_REG_RDATA);

  always_comb begin
    w_next       = r_state;
    w_data_o     = 8'h00;
    w_tx_ready   = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    w_capture_rd = 1'b0;
    w_drop_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_oe) begin
          if (reg_req)                      w_next = S_REG_CMD;
          else if (tx_valid && !r_tx_drop)  w_next = S_TX_CMD;
        end
      end
      S_REG_CMD: begin
        w_data_o = {1'b1, !r_we, reg_addr};
        if (ulpi_dir) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (ulpi_nxt) begin
          w_next = r_we ? S_REG_WDATA : S_REG_TURN;
        end
      end
      S_REG_WDATA: begin
        w_data_o = reg_wdata;
        if (ulpi_dir) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (ulpi_nxt) begin
          w_next = S_REG_STP;
        end
      end
      S_REG_STP: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_REG_TURN: begin
        if (ulpi_dir && w_turn) w_next = S_REG_RDATA;
      end
      S_REG_RDATA: begin
        // dir_r is already high here, so dir low means the PHY let go without data
        if (ulpi_dir) begin
          w_done       = 1'b1;
          w_capture_rd = 1'b1;
        end else begin
          w_abort = 1'b1;
        end
        w_next = S_IDLE;
      end
      S_TX_CMD: begin
        w_data_o = {4'h4, tx_data[3:0]};
        if (w_oe && ulpi_nxt) begin
          w_tx_ready = 1'b1;
          w_next     = tx_last ? S_TX_STP : S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        if (ulpi_dir) begin
          w_drop_set = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_tx_ready = ulpi_nxt;
          if (tx_valid) w_data_o = tx_data;
          if (tx_valid && ulpi_nxt && tx_last) w_next = S_TX_STP;
        end
      end
      S_TX_STP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // Remainder of a packet interrupted by the PHY is swallowed without bus activity
    if (r_tx_drop) w_tx_ready = 1'b1;
  end

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == C_FULL);
  assign w_pop   = !w_empty && rx_ready;
  assign w_wr    = w_rx_ok && ulpi_nxt;
  assign w_push  = w_wr && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_stp       <= 1'b0;
      r_we        <= 1'b0;
      r_tx_drop   <= 1'b0;
      r_reg_rdata <= 8'h00;
      r_rx_cmd    <= 8'h00;
      r_ovf       <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_state <= w_next;
      r_dir   <= ulpi_dir;
      r_stp   <= (w_next == S_TX_STP) || (w_next == S_REG_STP);
      r_ovf   <= w_wr && w_full && !w_pop;
      if (r_state == S_IDLE && w_next == S_REG_CMD) r_we <= reg_we;
      if (w_drop_set)                                r_tx_drop <= 1'b1;
      else if (r_tx_drop && tx_valid && tx_last)     r_tx_drop <= 1'b0;
      if (w_capture_rd)                              r_reg_rdata <= ulpi_data_i;
      if (w_rx_ok && !ulpi_nxt)                      r_rx_cmd <= ulpi_data_i;
      if (w_push)                                    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)                                     r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= ulpi_data_i;
  end

  assign ulpi_data_o  = w_data_o;
  assign ulpi_data_oe = w_oe;
  assign ulpi_stp     = r_stp;
  assign reg_done     = w_done;
  assign reg_abort    = w_abort;
  assign reg_rdata    = r_reg_rdata;
  assign tx_ready     = w_tx_ready;
  assign rx_valid     = !w_empty;
  assign rx_data      = r_mem[r_rd_ptr[AW-1:0]];
  assign rx_overflow  = r_ovf;
  assign rx_cmd       = r_rx_cmd;
  assign busy         = (r_state != S_IDLE) || ulpi_dir;

endmodule
`default_nettype wire

// File: tb/tb_ulpi_link_ctrl.sv
`default_nettype none
// Testbench for ulpi_link_ctrl: scripted PHY scenarios and randomized rounds,
// checked every cycle against a queue-based model of the bus and RX path.
module tb_ulpi_link_ctrl;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dir = 1'b0, nxt = 1'b0;
  logic [7:0] din = 8'h00;
  logic       reg_req = 1'b0, reg_we = 1'b0;
  logic [5:0] reg_addr = 6'h00;
  logic [7:0] reg_wdata = 8'h00;
  logic       tx_valid = 1'b0, tx_last = 1'b0, rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic [7:0] ulpi_data_o, reg_rdata, rx_data, rx_cmd;
  logic       ulpi_data_oe, ulpi_stp, reg_done, reg_abort, tx_ready;
  logic       rx_valid, rx_overflow, busy;

  always #5 clk = ~clk;

  ulpi_link_ctrl #(.RX_DEPTH(DEPTH), .TX_DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .ulpi_dir(dir), .ulpi_nxt(nxt), .ulpi_data_i(din),
    .ulpi_data_o(ulpi_data_o), .ulpi_data_oe(ulpi_data_oe), .ulpi_stp(ulpi_stp),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_done(reg_done), .reg_abort(reg_abort), .reg_rdata(reg_rdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_overflow(rx_overflow), .rx_cmd(rx_cmd), .busy(busy)
  );

  int n_tests = 0, n_fail = 0;

  logic [7:0] m_q[$];
  logic       m_dirp = 1'b0, m_ovf = 1'b0, m_block = 1'b0, mon_en = 1'b0;
  logic [7:0] m_rxcmd = 8'h00;
  logic [7:0] acc_q[$];
  int stp_cnt = 0, done_cnt = 0, abort_cnt = 0, ovf_cnt = 0, pop_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Outputs settle mid-cycle; the same point predicts what the next edge stores.
  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      logic mw, mpop;
      chk("oe", 32'(ulpi_data_oe), 32'(!dir && (dir == m_dirp)));
      chk("rx_valid", 32'(rx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(m_q[0]));
      chk("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
      chk("rx_cmd", 32'(rx_cmd), 32'(m_rxcmd));
      if (ulpi_stp) chk("stp_data", 32'(ulpi_data_o), 32'h0);
      if (dir) chk("busy_dir", 32'(busy), 32'h1);
      if (ulpi_data_oe && nxt) acc_q.push_back(ulpi_data_o);
      stp_cnt   += int'(ulpi_stp);
      done_cnt  += int'(reg_done);
      abort_cnt += int'(reg_abort);
      ovf_cnt   += int'(rx_overflow);
      if (tx_valid && tx_ready) pop_cnt++;
      mw    = dir && (dir == m_dirp) && nxt && !m_block;
      mpop  = (m_q.size() != 0) && rx_ready;
      m_ovf = mw && (m_q.size() == DEPTH) && !mpop;
      if (mpop) void'(m_q.pop_front());
      if (mw && m_q.size() < DEPTH) m_q.push_back(din);
      if (dir && (dir == m_dirp) && !nxt && !m_block) m_rxcmd = din;
      m_dirp = dir;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_q.delete(); m_ovf = 1'b0; m_rxcmd = 8'h00; m_dirp = 1'b0; m_block = 1'b0;
    dir = 1'b0; nxt = 1'b0; reg_req = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; rx_ready = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
  endtask

  task automatic reg_write(input logic [5:0] a, input logic [7:0] d, input int d0, input int d1);
    int s0 = stp_cnt, dn0 = done_cnt, ab0 = abort_cnt;
    acc_q.delete();
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d; nxt = 1'b0; cyc();
    repeat (d0) cyc();
    nxt = 1'b1; cyc(); nxt = 1'b0;
    repeat (d1) cyc();
    nxt = 1'b1; cyc(); nxt = 1'b0;
    chk("wr_stp_after_data", 32'(ulpi_stp), 32'h1);
    reg_req = 1'b0;
    repeat (3) cyc();
    chk("wr_bytes", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("wr_cmd_byte", 32'(acc_q[0]), 32'({2'b10, a}));
      chk("wr_data_byte", 32'(acc_q[1]), 32'(d));
    end
    chk("wr_stp_cycles", stp_cnt - s0, 1);
    chk("wr_done", done_cnt - dn0, 1);
    chk("wr_abort", abort_cnt - ab0, 0);
  endtask

  task automatic reg_read(input logic [5:0] a, input logic [7:0] d, input int d0, input int t);
    int s0 = stp_cnt, dn0 = done_cnt, ab0 = abort_cnt;
    acc_q.delete();
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = a; nxt = 1'b0; cyc();
    repeat (d0) cyc();
    nxt = 1'b1; cyc(); nxt = 1'b0;
    repeat (t) cyc();
    dir = 1'b1; din = 8'($urandom); cyc();
    din = d; m_block = 1'b1; cyc();
    m_block = 1'b0; reg_req = 1'b0; dir = 1'b0; cyc();
    cyc();
    chk("rd_rdata", 32'(reg_rdata), 32'(d));
    chk("rd_bytes", acc_q.size(), 1);
    if (acc_q.size() == 1) chk("rd_cmd_byte", 32'(acc_q[0]), 32'({2'b11, a}));
    chk("rd_done", done_cnt - dn0, 1);
    chk("rd_abort", abort_cnt - ab0, 0);
    chk("rd_no_stp", stp_cnt - s0, 0);
  endtask

  task automatic tx_packet(input logic [7:0] pkt[$], input bit stalls, input bit bump);
    int idx = 0, guard = 0, n = pkt.size();
    int p0 = pop_cnt, s0 = stp_cnt;
    bit popped, gap;
    acc_q.delete();
    tx_valid = 1'b1; tx_data = pkt[0]; tx_last = (n == 1); nxt = 1'b0; cyc();
    if (bump) begin
      dir = 1'b1; din = 8'($urandom); cyc(); cyc();
      dir = 1'b0; cyc();
    end
    while (idx < n && guard < 200) begin
      gap      = stalls && (idx >= 1) && ($urandom_range(0, 3) == 0);
      tx_valid = !gap;
      tx_data  = pkt[idx];
      tx_last  = (idx == n - 1);
      nxt      = gap ? 1'b0 : (stalls ? ($urandom_range(0, 2) != 0) : 1'b1);
      @(negedge clk);
      if (gap) chk("tx_gap_noop", 32'(ulpi_data_o), 32'h0);
      popped = tx_valid && tx_ready;
      @(posedge clk); #1;
      if (popped) idx++;
      guard++;
    end
    tx_valid = 1'b0; tx_last = 1'b0; nxt = 1'b0;
    chk("tx_stp_after_last", 32'(ulpi_stp), 32'h1);
    repeat (2) cyc();
    chk("tx_no_timeout", 32'(guard < 200), 32'h1);
    chk("tx_pops", pop_cnt - p0, n);
    chk("tx_stp_cycles", stp_cnt - s0, 1);
    chk("tx_bytes", acc_q.size(), n);
    if (acc_q.size() == n) begin
      chk("tx_pid_cmd", 32'(acc_q[0]), 32'({4'h4, pkt[0][3:0]}));
      for (int i = 1; i < n; i++) chk("tx_byte", 32'(acc_q[i]), 32'(pkt[i]));
    end
  endtask

  task automatic rx_burst(input int n, input int cmd_pct, input int rdy_pct);
    dir = 1'b1; nxt = 1'b0; din = 8'($urandom);
    rx_ready = ($urandom_range(0, 99) < rdy_pct); cyc();
    for (int i = 0; i < n; i++) begin
      nxt      = ($urandom_range(0, 99) >= cmd_pct);
      din      = 8'($urandom);
      rx_ready = ($urandom_range(0, 99) < rdy_pct);
      cyc();
    end
    dir = 1'b0; nxt = 1'b0; rx_ready = 1'b0; cyc();
  endtask

  task automatic rx_drain();
    int g = 0;
    while (m_q.size() != 0 && g < 200) begin
      rx_ready = ($urandom_range(0, 3) != 0); cyc(); g++;
    end
    rx_ready = 1'b0; cyc();
    chk("rx_drained", 32'(rx_valid), 32'h0);
  endtask

  task automatic abort_test(input logic [7:0] cmdbyte);
    int ab0 = abort_cnt, dn0 = done_cnt, s0 = stp_cnt;
    reg_req = 1'b1; reg_we = $urandom_range(0, 1); reg_addr = 6'($urandom); nxt = 1'b0; cyc();
    dir = 1'b1; din = 8'($urandom); cyc();
    reg_req = 1'b0; din = cmdbyte; cyc();
    dir = 1'b0; cyc(); cyc();
    chk("ab_abort", abort_cnt - ab0, 1);
    chk("ab_done", done_cnt - dn0, 0);
    chk("ab_stp", stp_cnt - s0, 0);
    chk("ab_rx_cmd", 32'(rx_cmd), 32'(cmdbyte));
    chk("ab_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pkt[$];
    int ov0;
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_data_o", 32'(ulpi_data_o), 32'h0);
    chk("rst_stp", 32'(ulpi_stp), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tx_ready", 32'(tx_ready), 32'h0);
    chk("rst_reg_rdata", 32'(reg_rdata), 32'h0);
    chk("rst_pulses", 32'({reg_done, reg_abort, rx_overflow}), 32'h0);
    @(posedge clk); #1;

    reg_write(6'h16, 8'h5A, 2, 2);
    if (acc_q.size() == 2) chk("w16_cmd_literal", 32'(acc_q[0]), 32'h96);

    reg_read(6'h0A, 8'h3C, 1, 2);
    chk("r0a_rdata_literal", 32'(reg_rdata), 32'h3C);

    pkt = '{8'hC3, 8'h11, 8'h22, 8'h33};
    tx_packet(pkt, 1'b1, 1'b0);
    if (acc_q.size() == 4) chk("tx_pid_literal", 32'(acc_q[0]), 32'h43);

    ov0 = ovf_cnt;
    rx_burst(20, 0, 0);
    chk("rx_ovf_literal", ovf_cnt - ov0, 4);
    chk("rx_stored_literal", m_q.size(), 16);
    rx_drain();

    abort_test(8'hA5);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 4))
        0: reg_write(6'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        1: reg_read(6'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        2: begin
          pkt.delete();
          for (int i = 0; i < $urandom_range(1, 6); i++) pkt.push_back(8'($urandom));
          tx_packet(pkt, $urandom_range(0, 1), $urandom_range(0, 1));
        end
        3: begin
          rx_burst($urandom_range(1, 30), $urandom_range(0, 40), $urandom_range(0, 100));
          if ($urandom_range(0, 1) == 1) rx_drain();
        end
        default: abort_test(8'($urandom));
      endcase
    end
    rx_drain();

    // Reset asserted with a packet in mid-flight
    tx_valid = 1'b1; tx_data = 8'h4B; tx_last = 1'b0; nxt = 1'b0; cyc();
    nxt = 1'b1; cyc();
    tx_data = 8'h77; cyc();
    nxt = 1'b0; #2;
    reset_n = 1'b0; #1;
    chk("mrst_data_o", 32'(ulpi_data_o), 32'h0);
    chk("mrst_stp", 32'(ulpi_stp), 32'h0);
    chk("mrst_tx_ready", 32'(tx_ready), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_reg_rdata", 32'(reg_rdata), 32'h0);
    chk("mrst_rx_cmd", 32'(rx_cmd), 32'h0);
    chk("mrst_oe", 32'(ulpi_data_oe), 32'h1);
    do_reset();
    cyc();
    chk("mrst_no_stp", 32'(ulpi_stp), 32'h0);
    reg_write(6'h04, 8'hE1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
